mem_port_arbiter: RTL and testbench

//  Shares one single-ported unified memory between the IF-stage instruction fetch and the
//  MEM-stage load/store of the five-stage pipeline. Arbitrates, sequences each access over a

---
 rtl/mem_port_arbiter.sv | 165 ++++++++++++++++
 tb/tb_mem_port_arbiter.sv | 243 ++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter
//   Shares one single-ported unified memory between the IF-stage instruction
//   fetch and the MEM-stage load/store. Each granted access is carried over a
//   variable-latency req/ready handshake. Read data is returned in registers
//   together with a one-cycle ack to the stage that owned the access.
//
// Ports
//   clk, reset            rising-edge clock, asynchronous active-low reset
//   if_req/if_addr        fetch request (level, held until if_ack) and PC
//   if_flush              branch taken: discard the pending or in-flight fetch
//   if_rdata/if_ack       fetched instruction, valid during the one-cycle ack
//   d_req/d_we/d_addr     data request (level, held until d_ack), store flag,
//   d_wdata               address and store data
//   d_rdata/d_ack         load data (zero for stores), one-cycle ack
//   mem_req/mem_we        memory request, held until mem_ready; write enable
//   mem_addr/mem_wdata    address and write data latched at grant
//   mem_rdata/mem_ready   memory read data and completion strobe
//   stall_if/stall_mem    combinational stall for each pipeline stage
//   bus_err               sticky: some access timed out, cleared by reset only
module mem_port_arbiter #(
  parameter int ADDR_W     = 32,
  parameter int DATA_W     = 32,
  parameter int STARVE_MAX = 4,
  parameter int TIMEOUT    = 15
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              if_req,
  input  logic [ADDR_W-1:0] if_addr,
  input  logic              if_flush,
  output logic [DATA_W-1:0] if_rdata,
  output logic              if_ack,
  input  logic              d_req,
  input  logic              d_we,
  input  logic [ADDR_W-1:0] d_addr,
  input  logic [DATA_W-1:0] d_wdata,
  output logic [DATA_W-1:0] d_rdata,
  output logic              d_ack,
  output logic              mem_req,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,
  input  logic              mem_ready,
  output logic              stall_if,
  output logic              stall_mem,
  output logic              bus_err
);

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] BUSY = 2'd1;
  localparam logic [1:0] RESP = 2'd2;

  localparam int SC_W = $clog2(STARVE_MAX + 1);
  localparam int WC_W = $clog2(TIMEOUT + 1);
  localparam logic [SC_W-1:0] STARVE_LIM = SC_W'(STARVE_MAX);
  localparam logic [WC_W-1:0] WAIT_LAST  = WC_W'(TIMEOUT - 1);

  logic [1:0]      state;
  logic            owner;       // 0 = fetch owns the access, 1 = data
  logic            drop;        // fetch was flushed while in flight
  logic [SC_W-1:0] starve_cnt;
  logic [WC_W-1:0] wait_cnt;

  logic grant_d;
  logic grant_if;
  logic timeout;
  logic drop_now;

  // Grant and completion decisions. Data wins a tie because it belongs to
  // the older instruction, unless the fetch has already lost too many times
  // in a row. drop_now also honours a flush arriving on the completing edge.
  always_comb begin
    grant_d  = d_req & ((starve_cnt < STARVE_LIM) | ~if_req);
    grant_if = ~grant_d & if_req & ~if_flush;
    timeout  = ~mem_ready & (wait_cnt == WAIT_LAST);
    drop_now = drop | (if_flush & ~owner);
  end

  assign stall_if  = if_req & ~if_ack;
  assign stall_mem = d_req & ~d_ack;

  // Access sequencer: IDLE grants and latches the request, BUSY holds
  // mem_req until ready or timeout, RESP presents the one-cycle ack.
  // A timed-out access still acks (with zero data) so the pipeline moves on.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state      <= IDLE;
      owner      <= 1'b0;
      drop       <= 1'b0;
      starve_cnt <= '0;
      wait_cnt   <= '0;
      mem_req    <= 1'b0;
      mem_we     <= 1'b0;
      mem_addr   <= '0;
      mem_wdata  <= '0;
      if_rdata   <= '0;
      d_rdata    <= '0;
      if_ack     <= 1'b0;
      d_ack      <= 1'b0;
      bus_err    <= 1'b0;
    end else begin
      if_ack <= 1'b0;
      d_ack  <= 1'b0;
      if (!if_req) begin
        starve_cnt <= '0;
      end
      case (state)
        IDLE: begin
          drop     <= 1'b0;
          wait_cnt <= '0;
          if (grant_d) begin
            owner     <= 1'b1;
            mem_req   <= 1'b1;
            mem_we    <= d_we;
            mem_addr  <= d_addr;
            mem_wdata <= d_wdata;
            state     <= BUSY;
            if (if_req && (starve_cnt != STARVE_LIM)) begin
              starve_cnt <= starve_cnt + SC_W'(1);
            end
          end else if (grant_if) begin
            owner      <= 1'b0;
            mem_req    <= 1'b1;
            mem_we     <= 1'b0;
            mem_addr   <= if_addr;
            state      <= BUSY;
            starve_cnt <= '0;
          end
        end
        BUSY: begin
          if (!owner && if_flush) begin
            drop <= 1'b1;
          end
          if (mem_ready || timeout) begin
            mem_req <= 1'b0;
            state   <= RESP;
            if (!mem_ready) begin
              bus_err <= 1'b1;
            end
            if (owner) begin
              d_ack   <= 1'b1;
              d_rdata <= (mem_ready && !mem_we) ? mem_rdata : '0;
            end else if (!drop_now) begin
              if_ack   <= 1'b1;
              if_rdata <= mem_ready ? mem_rdata : '0;
            end
          end else begin
            wait_cnt <= wait_cnt + WC_W'(1);
          end
        end
        RESP: begin
          if (!owner && if_flush) begin
            drop <= 1'b1;
          end
          state <= IDLE;
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// tb_mem_port_arbiter
//   Randomised requesters and a variable-latency memory drive the arbiter.
//   A transaction-level reference model predicts who is granted, how long the
//   memory request is held, when each ack arrives and which data it carries.
module tb_mem_port_arbiter;

  localparam int STARVE_MAX = 4;
  localparam int TIMEOUT    = 15;

  logic        clk = 1'b0;
  logic        reset;
  logic        if_req, if_flush, if_ack;
  logic [31:0] if_addr, if_rdata;
  logic        d_req, d_we, d_ack;
  logic [31:0] d_addr, d_wdata, d_rdata;
  logic        mem_req, mem_we, mem_ready;
  logic [31:0] mem_addr, mem_wdata, mem_rdata;
  logic        stall_if, stall_mem, bus_err;

  always #5 clk = ~clk;

  mem_port_arbiter #(
    .ADDR_W(32), .DATA_W(32), .STARVE_MAX(STARVE_MAX), .TIMEOUT(TIMEOUT)
  ) dut (
    .clk(clk), .reset(reset),
    .if_req(if_req), .if_addr(if_addr), .if_flush(if_flush),
    .if_rdata(if_rdata), .if_ack(if_ack),
    .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata),
    .d_rdata(d_rdata), .d_ack(d_ack),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .mem_ready(mem_ready),
    .stall_if(stall_if), .stall_mem(stall_mem), .bus_err(bus_err)
  );

  int checks = 0;
  int fails  = 0;

  // Reference model: phase 0 = memory free, 1 = access on the bus,
  // 2 = ack cycle. streak counts data wins while a fetch was waiting.
  int          phase;
  int          age;
  int          streak;
  int          lat;
  logic        owner_d, drop, grant_seen;
  logic        e_mem_req, e_if_ack, e_d_ack, e_err, e_we;
  logic [31:0] e_if_rdata, e_d_rdata, e_addr, e_wdata;

  int unsigned p_if, p_d, p_flush;
  int          forced_lat;
  logic [31:0] forced_rdata;
  int          req_cycles;

  // Compare one observed value with its expectation and count the result.
  task automatic checkOutput(input string tag, input logic [31:0] got,
                             input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      fails++;
      $display("[TB] FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  task automatic modelReset();
    phase = 0; age = 0; streak = 0; lat = 0;
    owner_d = 1'b0; drop = 1'b0; grant_seen = 1'b0;
    e_mem_req = 1'b0; e_if_ack = 1'b0; e_d_ack = 1'b0; e_err = 1'b0;
    e_we = 1'b0; e_if_rdata = '0; e_d_rdata = '0; e_addr = '0; e_wdata = '0;
  endtask

  // Memory latency in BUSY cycles; beyond TIMEOUT means it never answers.
  function automatic int pickLatency();
    int r;
    if (forced_lat > 0) return forced_lat;
    r = int'($urandom_range(0, 19));
    if (r == 0) return TIMEOUT + 3;
    return 1 + (r % 4);
  endfunction

  // One clock cycle, entered and left at the falling edge: check the
  // registered outputs, update the requesters and memory, check the stalls,
  // then advance the model over the coming rising edge.
  task automatic applyStimulus();
    checkOutput("mem_req", 32'(mem_req), 32'(e_mem_req));
    checkOutput("if_ack",  32'(if_ack),  32'(e_if_ack));
    checkOutput("d_ack",   32'(d_ack),   32'(e_d_ack));
    checkOutput("bus_err", 32'(bus_err), 32'(e_err));
    if (e_if_ack) checkOutput("if_rdata", if_rdata, e_if_rdata);
    if (e_d_ack)  checkOutput("d_rdata",  d_rdata,  e_d_rdata);
    if (grant_seen) begin
      checkOutput("mem_addr", mem_addr, e_addr);
      checkOutput("mem_we",   32'(mem_we), 32'(e_we));
      if (owner_d) checkOutput("mem_wdata", mem_wdata, e_wdata);
    end

    if (e_if_ack) if_req = 1'b0;
    if (e_d_ack)  d_req  = 1'b0;
    if (!if_req && $urandom_range(0, 99) < p_if) begin
      if_req  = 1'b1;
      if_addr = $urandom() & 32'h0000_0FFC;
    end
    if_flush = 1'b0;
    if (if_req && phase != 2 && $urandom_range(0, 99) < p_flush) begin
      if_flush = 1'b1;
      if_addr  = $urandom() & 32'h0000_0FFC;
    end
    if (!d_req && $urandom_range(0, 99) < p_d) begin
      d_req   = 1'b1;
      d_we    = 1'($urandom_range(0, 1));
      d_addr  = ($urandom() & 32'h0000_FFFC) | 32'h0001_0000;
      d_wdata = $urandom();
    end
    mem_rdata = (forced_rdata != 0) ? forced_rdata : $urandom();
    if (phase == 1) mem_ready = (age + 1 == lat);
    else            mem_ready = 1'($urandom_range(0, 1));

    #1;
    checkOutput("stall_if",  32'(stall_if),  32'(if_req & ~e_if_ack));
    checkOutput("stall_mem", 32'(stall_mem), 32'(d_req & ~e_d_ack));

    e_if_ack = 1'b0;
    e_d_ack = 1'b0;
    grant_seen = 1'b0;
    if (!if_req) streak = 0;
    if (phase == 0) begin
      if (d_req && (streak < STARVE_MAX || !if_req)) begin
        phase = 1; owner_d = 1'b1; age = 0; drop = 1'b0; grant_seen = 1'b1;
        e_mem_req = 1'b1; e_addr = d_addr; e_we = d_we; e_wdata = d_wdata;
        if (if_req && streak < STARVE_MAX) streak++;
        lat = pickLatency();
      end else if (if_req && !if_flush) begin
        phase = 1; owner_d = 1'b0; age = 0; drop = 1'b0; grant_seen = 1'b1;
        e_mem_req = 1'b1; e_addr = if_addr; e_we = 1'b0;
        streak = 0;
        lat = pickLatency();
      end
    end else if (phase == 1) begin
      age++;
      if (!owner_d && if_flush) drop = 1'b1;
      if (mem_ready || age == TIMEOUT) begin
        e_mem_req = 1'b0;
        phase = 2;
        if (!mem_ready) e_err = 1'b1;
        if (owner_d) begin
          e_d_ack   = 1'b1;
          e_d_rdata = (mem_ready && !e_we) ? mem_rdata : 32'h0;
        end else if (!drop) begin
          e_if_ack   = 1'b1;
          e_if_rdata = mem_ready ? mem_rdata : 32'h0;
        end
      end
    end else begin
      phase = 0;
    end

    @(posedge clk);
    @(negedge clk);
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation did not finish in time");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    reset = 1'b0;
    if_req = 1'b0; if_addr = '0; if_flush = 1'b0;
    d_req = 1'b0; d_we = 1'b0; d_addr = '0; d_wdata = '0;
    mem_ready = 1'b0; mem_rdata = '0;
    p_if = 0; p_d = 0; p_flush = 0; forced_lat = 0; forced_rdata = '0;
    modelReset();

    repeat (3) @(negedge clk);
    checkOutput("rst_mem_req",   32'(mem_req),   32'h0);
    checkOutput("rst_mem_we",    32'(mem_we),    32'h0);
    checkOutput("rst_mem_addr",  mem_addr,       32'h0);
    checkOutput("rst_mem_wdata", mem_wdata,      32'h0);
    checkOutput("rst_if_ack",    32'(if_ack),    32'h0);
    checkOutput("rst_d_ack",     32'(d_ack),     32'h0);
    checkOutput("rst_if_rdata",  if_rdata,       32'h0);
    checkOutput("rst_d_rdata",   d_rdata,        32'h0);
    checkOutput("rst_bus_err",   32'(bus_err),   32'h0);
    checkOutput("rst_stall_if",  32'(stall_if),  32'h0);
    reset = 1'b1;

    // Single fetch from 0x40 answered after two BUSY cycles.
    forced_lat = 2;
    forced_rdata = 32'h8C22_0004;
    if_req = 1'b1;
    if_addr = 32'h0000_0040;
    req_cycles = 0;
    for (int i = 0; i < 6; i++) begin
      if (mem_req) req_cycles++;
      applyStimulus();
    end
    checkOutput("fetch_busy_cycles", 32'(req_cycles), 32'd2);
    checkOutput("fetch_data", if_rdata, 32'h8C22_0004);
    forced_lat = 0;
    forced_rdata = '0;

    // Heavy data traffic: exercises ties, starvation limit and flushes.
    p_if = 60; p_d = 90; p_flush = 8;
    for (int i = 0; i < 400; i++) applyStimulus();

    // Lighter, mixed traffic.
    p_if = 35; p_d = 35; p_flush = 10;
    for (int i = 0; i < 400; i++) applyStimulus();

    // Drain everything outstanding.
    p_if = 0; p_d = 0; p_flush = 0;
    for (int i = 0; i < 80; i++) begin
      if (phase == 0 && !if_req && !d_req) break;
      applyStimulus();
    end

    // Store that never gets mem_ready: must time out and still ack.
    forced_lat = TIMEOUT + 5;
    d_req = 1'b1; d_we = 1'b1; d_addr = 32'h0000_0200; d_wdata = 32'hDEAD_BEEF;
    for (int i = 0; i < 20; i++) applyStimulus();
    checkOutput("timeout_bus_err", 32'(bus_err), 32'h1);

    // Reset in the middle of a load: everything clears asynchronously.
    d_req = 1'b1; d_we = 1'b0; d_addr = 32'h0000_0300;
    for (int i = 0; i < 4; i++) applyStimulus();
    checkOutput("pre_reset_mem_req", 32'(mem_req), 32'h1);
    reset = 1'b0;
    d_req = 1'b0;
    #1;
    checkOutput("midrst_mem_req", 32'(mem_req), 32'h0);
    checkOutput("midrst_d_ack",   32'(d_ack),   32'h0);
    checkOutput("midrst_if_ack",  32'(if_ack),  32'h0);
    checkOutput("midrst_bus_err", 32'(bus_err), 32'h0);
    modelReset();
    forced_lat = 0;
    @(negedge clk);
    reset = 1'b1;
    for (int i = 0; i < 5; i++) applyStimulus();

    $display("%0d/%0d checks passed", checks - fails, checks);
    $finish;
  end

endmodule
